motion_estimation: RTL and testbench

Full-search integer motion estimator for one MB_SIZE×MB_SIZE current block against a REF_FRAME_SIZE×REF_FRAME_SIZE reference window. It sits directly upstream of `motion_compensation` and produces the `mv_x`/`mv_y` pair that block consumes, plus the winning SAD. It evaluates one candidate position per clock, in raster order, using a start/busy/done handshake.

---
 rtl/motion_estimation_if.sv | 27 ++
 rtl/motion_estimation.sv | 121 ++++++++++++
 tb/tb_motion_estimation.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/motion_estimation_if.sv
// Search handshake and data bundle for motion_estimation.
// master = requester, slave = estimator.
interface motion_estimation_if #(
    parameter int MB_SIZE        = 4,
    parameter int PIXEL_WIDTH    = 8,
    parameter int REF_FRAME_SIZE = 8,
    parameter int SAD_WIDTH      = PIXEL_WIDTH + $clog2(MB_SIZE * MB_SIZE)
);
    logic                   start;
    logic [PIXEL_WIDTH-1:0] ref_frame [REF_FRAME_SIZE][REF_FRAME_SIZE];
    logic [PIXEL_WIDTH-1:0] curr_mb   [MB_SIZE][MB_SIZE];
    logic                   busy;
    logic                   done;
    logic [5:0]             mv_x;
    logic [5:0]             mv_y;
    logic [SAD_WIDTH-1:0]   min_sad;

    modport master (
        output start, ref_frame, curr_mb,
        input  busy, done, mv_x, mv_y, min_sad
    );

    modport slave (
        input  start, ref_frame, curr_mb,
        output busy, done, mv_x, mv_y, min_sad
    );
endinterface

// File: rtl/motion_estimation.sv
// Full-search SAD motion estimator, one candidate per clock in raster order.
// Define ME_EARLY_TERM_EN to stop the search at the first zero-SAD candidate.
module motion_estimation #(
    parameter int MB_SIZE        = 4,
    parameter int PIXEL_WIDTH    = 8,
    parameter int REF_FRAME_SIZE = 8,
    parameter int SAD_WIDTH      = PIXEL_WIDTH + $clog2(MB_SIZE * MB_SIZE)
) (
    input logic                clk,
    input logic                reset,
    motion_estimation_if.slave bus
);
    localparam int N  = REF_FRAME_SIZE - MB_SIZE + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (REF_FRAME_SIZE > 1) ? $clog2(REF_FRAME_SIZE) : 1;
    localparam int PW = PIXEL_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef ME_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cx, cy;
    logic [CW-1:0]        best_x, best_y;
    logic [SAD_WIDTH-1:0] best_sad;
    logic [PW-1:0]        ref_q [REF_FRAME_SIZE][REF_FRAME_SIZE];
    logic [PW-1:0]        cur_q [MB_SIZE][MB_SIZE];

    logic [SAD_WIDTH-1:0] sad;
    logic [PW-1:0]        rp;
    logic signed [PW:0]   d;
    logic [PW:0]          ad;
    logic                 acc;
    logic                 fin;

    // Input snapshot; only taken on the IDLE->SEARCH edge.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            ref_q <= bus.ref_frame;
            cur_q <= bus.curr_mb;
        end
    end

    always_comb begin
        sad = '0;
        rp  = '0;
        d   = '0;
        ad  = '0;
        for (int i = 0; i < MB_SIZE; i++) begin
            for (int j = 0; j < MB_SIZE; j++) begin
                rp  = ref_q[RW'(i) + RW'(cy)][RW'(j) + RW'(cx)];
                d   = $signed({1'b0, cur_q[i][j]}) - $signed({1'b0, rp});
                ad  = d[PW] ? (PW+1)'(-d) : (PW+1)'(d);
                sad = sad + SAD_WIDTH'(ad);
            end
        end
    end

    // First candidate always wins; later ones only on a strict improvement.
    assign acc = ((cx == '0) && (cy == '0)) || (sad < best_sad);
    assign fin = ((cx == LAST) && (cy == LAST))
               || (EARLY && acc && (sad == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cx          <= '0;
            cy          <= '0;
            best_x      <= '0;
            best_y      <= '0;
            best_sad    <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.mv_x    <= '0;
            bus.mv_y    <= '0;
            bus.min_sad <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state    <= SEARCH;
                        bus.busy <= 1'b1;
                        cx       <= '0;
                        cy       <= '0;
                    end
                end
                SEARCH: begin
                    if (acc) begin
                        best_sad <= sad;
                        best_x   <= cx;
                        best_y   <= cy;
                    end
                    if (fin) begin
                        state       <= DONE;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.mv_x    <= acc ? 6'(cx) : 6'(best_x);
                        bus.mv_y    <= acc ? 6'(cy) : 6'(best_y);
                        bus.min_sad <= acc ? sad : best_sad;
                    end else if (cx == LAST) begin
                        cx <= '0;
                        cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_motion_estimation.sv
// Scoreboard bench for motion_estimation: random and directed searches
// checked against a plain full-search reference model.
module tb_motion_estimation;
    localparam int M = 4;
    localparam int R = 8;
    localparam int N = R - M + 1;

    typedef struct {
        int mx;
        int my;
        int sad;
        int lat;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];

    logic [7:0] rf [R][R];
    logic [7:0] cm [M][M];

    motion_estimation_if bus ();

    motion_estimation dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        int best;
        int s;
        best = -1;
        e.mx = 0;
        e.my = 0;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++) begin
                s = 0;
                for (int i = 0; i < M; i++)
                    for (int j = 0; j < M; j++) begin
                        if (cm[i][j] > rf[y+i][x+j])
                            s += int'(cm[i][j]) - int'(rf[y+i][x+j]);
                        else
                            s += int'(rf[y+i][x+j]) - int'(cm[i][j]);
                    end
                if (best < 0 || s < best) begin
                    best = s;
                    e.mx = x;
                    e.my = y;
                end
            end
        e.sad = best;
        e.lat = N * N;
`ifdef ME_EARLY_TERM_EN
        if (best == 0) e.lat = e.my * N + e.mx + 1;
`endif
        e.cyc = 0;
        return e;
    endfunction

    task automatic drive();
        bus.ref_frame = rf;
        bus.curr_mb   = cm;
    endtask

    task automatic rand_frame(input int lo, input int hi);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < R; c++)
                rf[r][c] = 8'($urandom_range(hi, lo));
    endtask

    task automatic rand_cur(input int lo, input int hi);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                cm[i][j] = 8'($urandom_range(hi, lo));
    endtask

    task automatic grad_frame();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < R; c++)
                rf[r][c] = 8'(r * 8 + c);
    endtask

    task automatic cut_block(input int by, input int bx);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                cm[i][j] = rf[by+i][bx+j];
    endtask

    task automatic fill(input int rv, input int cv);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < R; c++)
                rf[r][c] = 8'(rv);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                cm[i][j] = 8'(cv);
    endtask

    // Called at a negedge with rf/cm set; returns after the result is due.
    task automatic run(input string nm);
        exp_t e;
        drive();
        e = model();
        e.cyc = cyc + 1 + e.lat;
        q.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rand_frame(0, 255);
        rand_cur(0, 255);
        drive();
        repeat (e.lat + 2) @(negedge clk);
        chk({nm, "_pending"}, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("mv_x", 32'(bus.mv_x), 32'(e.mx));
                chk("mv_y", 32'(bus.mv_y), 32'(e.my));
                chk("min_sad", 32'(bus.min_sad), 32'(e.sad));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    initial begin
        exp_t e;
        exp_t e2;
        bus.start = 1'b0;
        fill(0, 0);
        drive();
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mv_x", 32'(bus.mv_x), 32'd0);
        chk("rst_mv_y", 32'(bus.mv_y), 32'd0);
        chk("rst_sad", 32'(bus.min_sad), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);

        grad_frame(); cut_block(2, 3); run("exact");
        grad_frame(); cut_block(4, 4); run("corner");
        fill(0, 255); run("max_sad");
        fill(10, 12); run("tie");

        for (int k = 0; k < 6; k++) begin
            rand_frame(0, 255);
            rand_cur(0, 255);
            run("rand");
        end
        for (int k = 0; k < 6; k++) begin
            rand_frame(0, 255);
            cut_block($urandom_range(N - 1, 0), $urandom_range(N - 1, 0));
            run("embed");
        end

        // Start pulses in SEARCH and in DONE must not cause a second search.
        rand_frame(0, 100);
        rand_cur(150, 255);
        drive();
        e = model();
        e.cyc = cyc + 1 + e.lat;
        q.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (e.lat - 5) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        chk("ignore_pending", 32'(q.size()), 32'd0);
        q.delete();

        // Held start restarts right after DONE->IDLE.
        grad_frame(); cut_block(1, 1); drive();
        e = model();
        e.cyc = cyc + 1 + e.lat;
        e2 = e;
        e2.cyc = e.cyc + 2 + e.lat;
        q.push_back(e);
        q.push_back(e2);
        bus.start = 1'b1;
        repeat (e.lat + 3) @(negedge clk);
        bus.start = 1'b0;
        repeat (e.lat + 3) @(negedge clk);
        chk("hold_pending", 32'(q.size()), 32'd0);
        q.delete();

        // Reset in SEARCH cycle 10: cleared outputs, no done.
        grad_frame(); cut_block(3, 2); drive();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_done", 32'(bus.done), 32'd0);
        chk("mid_mv_x", 32'(bus.mv_x), 32'd0);
        chk("mid_mv_y", 32'(bus.mv_y), 32'd0);
        chk("mid_sad", 32'(bus.min_sad), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_idle_busy", 32'(bus.busy), 32'd0);
        grad_frame(); cut_block(3, 2); run("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
